// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_pkg
//  Description : Shared types and encodings for the multi-cycle RV32I control
//                FSM: state encoding, instruction classes, opcode values,
//                PC-source and writeback-select encodings, and the opcode to
//                class decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

   // Control FSM state. The numeric values are visible on state_o.
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   // Instruction class, latched once per instruction in DECODE.
   typedef enum logic [3:0] {
      CLS_RTYPE   = 4'd0,
      CLS_IALU    = 4'd1,
      CLS_LOAD    = 4'd2,
      CLS_STORE   = 4'd3,
      CLS_BRANCH  = 4'd4,
      CLS_JAL     = 4'd5,
      CLS_JALR    = 4'd6,
      CLS_LUI     = 4'd7,
      CLS_AUIPC   = 4'd8,
      CLS_FENCE   = 4'd9,
      CLS_SYSTEM  = 4'd10,
      CLS_ILLEGAL = 4'd11
   } iclass_e;

   // RV32I major opcodes
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_IALU   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // PC next-value select
   localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;  // PC + 4
   localparam logic [1:0] PC_SRC_IMM   = 2'd1;  // PC + imm
   localparam logic [1:0] PC_SRC_ALU   = 2'd2;  // ALU result & ~1

   // Register-file writeback select
   localparam logic [1:0] WB_SEL_ALU  = 2'd0;
   localparam logic [1:0] WB_SEL_LOAD = 2'd1;
   localparam logic [1:0] WB_SEL_PC4  = 2'd2;
   localparam logic [1:0] WB_SEL_IMM  = 2'd3;

   // Map a major opcode to its instruction class; unknown opcodes are ILLEGAL.
   function automatic iclass_e decode_class(input logic [6:0] opc);
      iclass_e cls;
      case (opc)
         OPC_RTYPE  : cls = CLS_RTYPE;
         OPC_IALU   : cls = CLS_IALU;
         OPC_LOAD   : cls = CLS_LOAD;
         OPC_STORE  : cls = CLS_STORE;
         OPC_BRANCH : cls = CLS_BRANCH;
         OPC_JAL    : cls = CLS_JAL;
         OPC_JALR   : cls = CLS_JALR;
         OPC_LUI    : cls = CLS_LUI;
         OPC_AUIPC  : cls = CLS_AUIPC;
         OPC_FENCE  : cls = CLS_FENCE;
         OPC_SYSTEM : cls = CLS_SYSTEM;
         default    : cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_br_cond.sv
`default_nettype none
// ============================================================================
//  Module      : br_cond
//  Description : Combinational RV32I branch-condition evaluator. Turns the
//                branch funct3 and the ALU comparison flags into a taken
//                decision, and flags the two reserved funct3 codes.
//  Ports       : funct3_i   - branch funct3 field
//                zero_i     - ALU result == 0 (src1 == src2 for SUB)
//                lt_i       - signed src1 < src2
//                ltu_i      - unsigned src1 < src2
//                taken_o    - branch condition holds
//                illegal_o  - funct3 is 010 or 011 (no such branch)
//  Revision    : 1.0 - initial release
// ============================================================================
module br_cond (
   input  logic [2:0] funct3_i,
   input  logic       zero_i,
   input  logic       lt_i,
   input  logic       ltu_i,
   output logic       taken_o,
   output logic       illegal_o
);

   always_comb begin
      taken_o   = 1'b0;
      illegal_o = 1'b0;
      case (funct3_i)
         3'b000  : taken_o = zero_i;    // BEQ
         3'b001  : taken_o = ~zero_i;   // BNE
         3'b100  : taken_o = lt_i;      // BLT
         3'b101  : taken_o = ~lt_i;     // BGE
         3'b110  : taken_o = ltu_i;     // BLTU
         3'b111  : taken_o = ~ltu_i;    // BGEU
         default : illegal_o = 1'b1;    // 010, 011 reserved
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl
//  Description : Multi-cycle control FSM for a single-issue RV32I datapath.
//                Sequences FETCH/DECODE/EXEC/MEM/WB, drives PC/IR/regfile
//                enables and datapath muxes, runs the data-memory req/ready
//                handshake with an optional timeout, evaluates branches and
//                counts retired instructions.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                opcode_i, funct3_i  - fields of the IR-held instruction
//                alu_zero_i/lt_i/ltu_i - ALU comparison flags
//                dmem_ready_i        - data memory completes access
//                ir_we_o, pc_we_o, pc_src_o       - fetch / PC control
//                alu_src1_sel_o, alu_src2_sel_o   - ALU operand muxes
//                rf_we_o, wb_sel_o                - register writeback
//                dmem_req_o, dmem_we_o            - data memory request
//                state_o, halted_o, illegal_o, bus_err_o - status
//                instret_o                        - retired instruction count
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int unsigned DMEM_TIMEOUT = 16,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode_i,
   input  logic [2:0]       funct3_i,
   input  logic             alu_zero_i,
   input  logic             alu_lt_i,
   input  logic             alu_ltu_i,
   input  logic             dmem_ready_i,
   output logic             ir_we_o,
   output logic             pc_we_o,
   output logic [1:0]       pc_src_o,
   output logic             alu_src1_sel_o,
   output logic             alu_src2_sel_o,
   output logic             rf_we_o,
   output logic [1:0]       wb_sel_o,
   output logic             dmem_req_o,
   output logic             dmem_we_o,
   output logic [2:0]       state_o,
   output logic             halted_o,
   output logic             illegal_o,
   output logic             bus_err_o,
   output logic [CNT_W-1:0] instret_o
);

   // The wait counter only has to reach DMEM_TIMEOUT-1: the timeout fires on
   // the cycle the counter already shows that many earlier empty MEM cycles.
   localparam int unsigned TMO_W    = (DMEM_TIMEOUT < 2) ? 1 : $clog2(DMEM_TIMEOUT);
   localparam bit          TMO_EN   = (DMEM_TIMEOUT != 0);
   localparam int unsigned TMO_LASTI = (DMEM_TIMEOUT == 0) ? 0 : DMEM_TIMEOUT - 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LASTI);

   state_e             state_q,   state_d;
   iclass_e            class_q,   class_d;
   logic               illegal_q, illegal_d;
   logic               bus_err_q, bus_err_d;
   logic [TMO_W-1:0]   tmo_q,     tmo_d;
   logic [CNT_W-1:0]   instret_q, instret_d;
   logic               retire;

   logic               br_taken;
   logic               br_illegal;

   br_cond u_br_cond (
      .funct3_i  (funct3_i),
      .zero_i    (alu_zero_i),
      .lt_i      (alu_lt_i),
      .ltu_i     (alu_ltu_i),
      .taken_o   (br_taken),
      .illegal_o (br_illegal)
   );

   // ------------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      class_d        = class_q;
      illegal_d      = illegal_q;
      bus_err_d      = bus_err_q;
      tmo_d          = tmo_q;
      retire         = 1'b0;

      ir_we_o        = 1'b0;
      pc_we_o        = 1'b0;
      pc_src_o       = PC_SRC_PLUS4;
      alu_src1_sel_o = 1'b0;
      alu_src2_sel_o = 1'b0;
      rf_we_o        = 1'b0;
      wb_sel_o       = WB_SEL_ALU;
      dmem_req_o     = 1'b0;
      dmem_we_o      = 1'b0;

      // The datapath has no ALU output register, so the operand selection
      // chosen in EXEC is held through MEM (address) and WB (ALU writeback).
      if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
         alu_src1_sel_o = (class_q == CLS_AUIPC);
         alu_src2_sel_o = !(class_q == CLS_RTYPE || class_q == CLS_BRANCH);
      end

      case (state_q)
         ST_FETCH: begin
            ir_we_o = 1'b1;
            state_d = ST_DECODE;
         end

         ST_DECODE: begin
            class_d = decode_class(opcode_i);
            if (class_d == CLS_ILLEGAL) begin
               illegal_d = 1'b1;
               state_d   = ST_HALT;
            end else if (class_d == CLS_SYSTEM) begin
               state_d   = ST_HALT;
            end else begin
               state_d   = ST_EXEC;
            end
         end

         ST_EXEC: begin
            case (class_q)
               CLS_BRANCH: begin
                  if (br_illegal) begin
                     illegal_d = 1'b1;
                     state_d   = ST_HALT;
                  end else begin
                     pc_we_o  = 1'b1;
                     pc_src_o = br_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
                     retire   = 1'b1;
                     state_d  = ST_FETCH;
                  end
               end
               CLS_FENCE: begin
                  pc_we_o = 1'b1;
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end
               CLS_LOAD, CLS_STORE: state_d = ST_MEM;
               default:             state_d = ST_WB;
            endcase
         end

         ST_MEM: begin
            dmem_req_o = 1'b1;
            dmem_we_o  = (class_q == CLS_STORE);
            // Ready is tested first so a completion on the timeout cycle wins.
            if (dmem_ready_i) begin
               tmo_d = '0;
               if (class_q == CLS_STORE) begin
                  pc_we_o = 1'b1;
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end else if (TMO_EN) begin
               if (tmo_q == TMO_LAST) begin
                  bus_err_d = 1'b1;
                  tmo_d     = '0;
                  state_d   = ST_HALT;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
         end

         ST_WB: begin
            rf_we_o = 1'b1;
            pc_we_o = 1'b1;
            case (class_q)
               CLS_LOAD:           wb_sel_o = WB_SEL_LOAD;
               CLS_JAL, CLS_JALR:  wb_sel_o = WB_SEL_PC4;
               CLS_LUI:            wb_sel_o = WB_SEL_IMM;
               default:            wb_sel_o = WB_SEL_ALU;
            endcase
            case (class_q)
               CLS_JAL:  pc_src_o = PC_SRC_IMM;
               CLS_JALR: pc_src_o = PC_SRC_ALU;
               default:  pc_src_o = PC_SRC_PLUS4;
            endcase
            retire  = 1'b1;
            state_d = ST_FETCH;
         end

         ST_HALT: state_d = ST_HALT;

         // Unused encodings can only appear through an upset; park safely.
         default: state_d = ST_HALT;
      endcase

      instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         class_q   <= CLS_RTYPE;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
         tmo_q     <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
         tmo_q     <= tmo_d;
         instret_q <= instret_d;
      end
   end

   assign state_o   = state_q;
   assign halted_o  = (state_q == ST_HALT);
   assign illegal_o = illegal_q;
   assign bus_err_o = bus_err_q;
   assign instret_o = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_ctrl
//  Description : Self-checking bench for mc_ctrl. A table of single
//                instructions is stepped from FETCH until the FSM returns to
//                FETCH or halts; the observed cycle count, enables and mux
//                selects are compared with hand-computed values. Short
//                hand-written sequences cover the state trace, HALT
//                persistence and reset in the middle of a memory access.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        zero, lt, ltu, ready;
   logic        ir_we, pc_we, src1, src2, rf_we, dreq, dwe, halted, illegal, bus_err;
   logic [1:0]  pc_src, wb_sel;
   logic [2:0]  state;
   logic [31:0] instret;

   always #5 clk = ~clk;

   mc_ctrl #(.DMEM_TIMEOUT(16), .CNT_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .opcode_i       (opcode),
      .funct3_i       (funct3),
      .alu_zero_i     (zero),
      .alu_lt_i       (lt),
      .alu_ltu_i      (ltu),
      .dmem_ready_i   (ready),
      .ir_we_o        (ir_we),
      .pc_we_o        (pc_we),
      .pc_src_o       (pc_src),
      .alu_src1_sel_o (src1),
      .alu_src2_sel_o (src2),
      .rf_we_o        (rf_we),
      .wb_sel_o       (wb_sel),
      .dmem_req_o     (dreq),
      .dmem_we_o      (dwe),
      .state_o        (state),
      .halted_o       (halted),
      .illegal_o      (illegal),
      .bus_err_o      (bus_err),
      .instret_o      (instret)
   );

   int checks   = 0;
   int failures = 0;
   longint exp_instret = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_instret = 0;
   endtask

   typedef struct {
      logic [6:0] opc;
      logic [2:0] f3;
      logic       z, l, lu;
      int         waitc;   // MEM cycles before ready is given
      int         cyc;     // cycles from FETCH until back in FETCH / HALT
      int         rfwe;    // cycles with rf_we_o
      logic [1:0] wbsel;   // wb_sel_o while rf_we_o
      int         pcwe;    // cycles with pc_we_o
      logic [1:0] pcsrc;   // pc_src_o while pc_we_o
      int         req;     // cycles with dmem_req_o
      logic       dwe;     // dmem_we_o seen while requesting
      logic       s1, s2;  // operand selects in EXEC
      int         ret;     // instret increment
      int         endst;   // 0 = FETCH, 5 = HALT
      logic       ill, berr;
   } vec_t;

   vec_t vecs[22];

   initial begin
      // opc f3 z l lu wait cyc rfwe wbsel pcwe pcsrc req dwe s1 s2 ret end ill berr
      vecs[0]  = '{7'b0110011, 3'd0, 0,0,0, 0,    4, 1, 2'd0, 1, 2'd0, 0,  0, 0,0, 1, 0, 0,0}; // ADD
      vecs[1]  = '{7'b0010011, 3'd0, 0,0,0, 0,    4, 1, 2'd0, 1, 2'd0, 0,  0, 0,1, 1, 0, 0,0}; // ADDI
      vecs[2]  = '{7'b1100011, 3'd0, 1,0,0, 0,    3, 0, 2'd0, 1, 2'd1, 0,  0, 0,0, 1, 0, 0,0}; // BEQ taken
      vecs[3]  = '{7'b1100011, 3'd0, 0,0,0, 0,    3, 0, 2'd0, 1, 2'd0, 0,  0, 0,0, 1, 0, 0,0}; // BEQ not taken
      vecs[4]  = '{7'b1100011, 3'd1, 0,0,0, 0,    3, 0, 2'd0, 1, 2'd1, 0,  0, 0,0, 1, 0, 0,0}; // BNE taken
      vecs[5]  = '{7'b1100011, 3'd4, 0,1,0, 0,    3, 0, 2'd0, 1, 2'd1, 0,  0, 0,0, 1, 0, 0,0}; // BLT taken
      vecs[6]  = '{7'b1100011, 3'd5, 0,1,0, 0,    3, 0, 2'd0, 1, 2'd0, 0,  0, 0,0, 1, 0, 0,0}; // BGE not taken
      vecs[7]  = '{7'b1100011, 3'd6, 0,0,1, 0,    3, 0, 2'd0, 1, 2'd1, 0,  0, 0,0, 1, 0, 0,0}; // BLTU taken
      vecs[8]  = '{7'b1100011, 3'd7, 0,0,0, 0,    3, 0, 2'd0, 1, 2'd1, 0,  0, 0,0, 1, 0, 0,0}; // BGEU taken
      vecs[9]  = '{7'b1100011, 3'd2, 1,1,1, 0,    3, 0, 2'd0, 0, 2'd0, 0,  0, 0,0, 0, 5, 1,0}; // branch f3=010
      vecs[10] = '{7'b0000011, 3'd2, 0,0,0, 3,    8, 1, 2'd1, 1, 2'd0, 4,  0, 0,1, 1, 0, 0,0}; // LW, 3 waits
      vecs[11] = '{7'b0100011, 3'd2, 0,0,0, 0,    4, 0, 2'd0, 1, 2'd0, 1,  1, 0,1, 1, 0, 0,0}; // SW, no wait
      vecs[12] = '{7'b0100011, 3'd2, 0,0,0, 2,    6, 0, 2'd0, 1, 2'd0, 3,  1, 0,1, 1, 0, 0,0}; // SW, 2 waits
      vecs[13] = '{7'b1101111, 3'd0, 0,0,0, 0,    4, 1, 2'd2, 1, 2'd1, 0,  0, 0,1, 1, 0, 0,0}; // JAL
      vecs[14] = '{7'b1100111, 3'd0, 0,0,0, 0,    4, 1, 2'd2, 1, 2'd2, 0,  0, 0,1, 1, 0, 0,0}; // JALR
      vecs[15] = '{7'b0110111, 3'd0, 0,0,0, 0,    4, 1, 2'd3, 1, 2'd0, 0,  0, 0,1, 1, 0, 0,0}; // LUI
      vecs[16] = '{7'b0010111, 3'd0, 0,0,0, 0,    4, 1, 2'd0, 1, 2'd0, 0,  0, 1,1, 1, 0, 0,0}; // AUIPC
      vecs[17] = '{7'b0001111, 3'd0, 0,0,0, 0,    3, 0, 2'd0, 1, 2'd0, 0,  0, 0,1, 1, 0, 0,0}; // FENCE
      vecs[18] = '{7'b1110011, 3'd0, 0,0,0, 0,    2, 0, 2'd0, 0, 2'd0, 0,  0, 0,0, 0, 5, 0,0}; // SYSTEM
      vecs[19] = '{7'b0000000, 3'd0, 0,0,0, 0,    2, 0, 2'd0, 0, 2'd0, 0,  0, 0,0, 0, 5, 1,0}; // illegal opc
      vecs[20] = '{7'b0100011, 3'd2, 0,0,0, 1000,19, 0, 2'd0, 0, 2'd0, 16, 1, 0,1, 0, 5, 0,1}; // SW timeout
      vecs[21] = '{7'b1100011, 3'd3, 0,0,0, 0,    3, 0, 2'd0, 0, 2'd0, 0,  0, 0,0, 0, 5, 1,0}; // branch f3=011
   end

   initial begin
      int   cyc, rfwe_n, pcwe_n, req_n, memc;
      logic [1:0] wbsel_s, pcsrc_s;
      logic dwe_s, s1_s, s2_s, done;

      opcode = 7'b0110011; funct3 = 3'd0; zero = 0; lt = 0; ltu = 0; ready = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("reset_state",   state,   0);
      check("reset_halted",  halted,  0);
      check("reset_illegal", illegal, 0);
      check("reset_bus_err", bus_err, 0);
      check("reset_instret", instret, 0);

      // ADD state trace: FETCH, DECODE, EXEC, WB, FETCH
      begin
         int trace[5];
         trace = '{0, 1, 2, 4, 0};
         for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("add_trace_state%0d", k), state, trace[k]);
            check($sformatf("add_trace_rfwe%0d", k), rf_we, (trace[k] == 4) ? 1 : 0);
         end
         exp_instret++;
         check("add_trace_instret", instret, exp_instret);
      end
      @(posedge clk); #1;   // back on a FETCH cycle boundary
      do_reset();

      // Table-driven single-instruction vectors
      for (int i = 0; i < 22; i++) begin
         opcode = vecs[i].opc; funct3 = vecs[i].f3;
         zero = vecs[i].z; lt = vecs[i].l; ltu = vecs[i].lu; ready = 0;
         cyc = 0; rfwe_n = 0; pcwe_n = 0; req_n = 0; memc = 0;
         wbsel_s = 0; pcsrc_s = 0; dwe_s = 0; s1_s = 0; s2_s = 0; done = 0;
         check($sformatf("v%0d_start_state", i), state, 0);
         while (!done && cyc < 64) begin
            @(negedge clk);
            if (state == 3'd3) begin
               ready = (memc >= vecs[i].waitc);
               memc++;
            end else begin
               ready = 1'b0;
            end
            #1;
            if (rf_we) begin rfwe_n++; wbsel_s = wb_sel; end
            if (pc_we) begin pcwe_n++; pcsrc_s = pc_src; end
            if (dreq)  begin req_n++;  dwe_s = dwe_s | dwe; end
            if (state == 3'd2) begin s1_s = src1; s2_s = src2; end
            cyc++;
            @(posedge clk); #1;
            if (state == 3'd0 || state == 3'd5) done = 1;
         end
         ready = 1'b0;
         if (!done) begin
            failures++;
            checks++;
            $display("FAIL v%0d_bound: no FETCH/HALT within 64 cycles, state %0d", i, state);
         end
         exp_instret += vecs[i].ret;
         check($sformatf("v%0d_cycles", i),  cyc,     vecs[i].cyc);
         check($sformatf("v%0d_rf_we", i),   rfwe_n,  vecs[i].rfwe);
         check($sformatf("v%0d_wb_sel", i),  wbsel_s, vecs[i].wbsel);
         check($sformatf("v%0d_pc_we", i),   pcwe_n,  vecs[i].pcwe);
         check($sformatf("v%0d_pc_src", i),  pcsrc_s, vecs[i].pcsrc);
         check($sformatf("v%0d_req", i),     req_n,   vecs[i].req);
         check($sformatf("v%0d_dwe", i),     dwe_s,   vecs[i].dwe);
         check($sformatf("v%0d_src1", i),    s1_s,    vecs[i].s1);
         check($sformatf("v%0d_src2", i),    s2_s,    vecs[i].s2);
         check($sformatf("v%0d_end", i),     state,   vecs[i].endst);
         check($sformatf("v%0d_halted", i),  halted,  (vecs[i].endst == 5) ? 1 : 0);
         check($sformatf("v%0d_illegal", i), illegal, vecs[i].ill);
         check($sformatf("v%0d_bus_err", i), bus_err, vecs[i].berr);
         check($sformatf("v%0d_instret", i), instret, exp_instret);
         if (vecs[i].endst == 5) begin
            do_reset();
            check($sformatf("v%0d_rst_state", i),   state,   0);
            check($sformatf("v%0d_rst_flags", i),   {illegal, bus_err, halted}, 0);
            check($sformatf("v%0d_rst_instret", i), instret, 0);
         end
      end

      // HALT is absorbing after a bus error; only rst leaves it
      begin
         int n;
         opcode = 7'b0100011; funct3 = 3'd2; ready = 0; n = 0;
         while (state != 3'd5 && n < 40) begin
            @(posedge clk); #1;
            n++;
         end
         check("halt_reached", state, 5);
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ready = 1'b1;   // a late ready must not revive the access
            #1;
            check($sformatf("halt_hold_state%0d", k), state, 5);
            check($sformatf("halt_hold_enables%0d", k),
                  {ir_we, pc_we, rf_we, dreq, halted, bus_err}, 6'b000011);
         end
         check("halt_instret", instret, exp_instret);
         do_reset();
         @(negedge clk);
         check("halt_rst_state", state, 0);
         check("halt_rst_flags", {illegal, bus_err, halted}, 0);
      end

      // Reset while a store is waiting in MEM
      begin
         int n;
         opcode = 7'b0100011; funct3 = 3'd2; ready = 0; n = 0;
         while (state != 3'd3 && n < 10) begin
            @(posedge clk); #1;
            n++;
         end
         @(negedge clk);
         check("midmem_req_before", dreq, 1);
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         check("midmem_req_after", dreq, 0);
         check("midmem_state", state, 0);
         check("midmem_wes", {pc_we, rf_we, dwe}, 0);
         check("midmem_instret", instret, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global guard so the run always ends
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
